// File: rtl/s820_bist_pkg.sv
// s820_bist_pkg: shared widths, FSM states and LFSR/MISR step functions for the s820 BIST controller
package s820_bist_pkg;
  localparam int PI_W = 18;
  localparam int PO_W = 19;
  localparam int CNT_W = 16;
  localparam logic [PI_W-1:0] LFSR_TAP = 18'h20400;
  localparam logic [PI_W-1:0] LFSR_ONE = 18'h00001;
  localparam logic [PI_W-1:0] PI_CLR = 18'h20000;
  localparam logic [PO_W-1:0] MISR_TAP = 19'h00047;
  typedef enum logic [1:0] {IDLE, INIT, APPLY, FINISH} state_t;
  function automatic logic [PI_W-1:0] lfsr_step(input logic [PI_W-1:0] q);
    return {q[PI_W-2:0], ^(q & LFSR_TAP)};
  endfunction
  function automatic logic [PO_W-1:0] misr_step(input logic [PO_W-1:0] m, input logic [PO_W-1:0] d);
    return {m[PO_W-2:0], 1'b0} ^ (m[PO_W-1] ? MISR_TAP : '0) ^ d;
  endfunction
endpackage

// File: rtl/s820_bist_misr.sv
// s820_bist_misr: 19-bit multiple-input signature register compacting DUT responses
module s820_bist_misr
  import s820_bist_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [PO_W-1:0] din,
  output logic [PO_W-1:0] sig
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= '0;
    else if (clr) sig <= '0;
    else if (en) sig <= misr_step(sig, din);
endmodule

// File: rtl/s820_bist.sv
// s820_bist_ctrl: BIST session FSM driving s820 with LFSR patterns and compacting responses into a MISR
module s820_bist_ctrl
  import s820_bist_pkg::*;
#(
  parameter int INIT_CYC = 2
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [PI_W-1:0]  SEED,
  input  logic [CNT_W-1:0] NUM_PAT,
  input  logic [PO_W-1:0]  GOLDEN,
  output logic [PI_W-1:0]  DUT_PI,
  input  logic [PO_W-1:0]  DUT_PO,
  output logic             BUSY,
  output logic             DONE,
  output logic [PO_W-1:0]  SIGNATURE,
  output logic             PASS
);
  localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);
  state_t state, state_n;
  logic [PI_W-1:0] lfsr, lfsr_n;
  logic [CNT_W-1:0] num_pat, pat_cnt;
  logic [PO_W-1:0] golden, misr_sig;
  logic [3:0] init_cnt;
  logic accept, init_done, pat_done;
  assign accept = (state == IDLE) && START;
  assign init_done = init_cnt == INIT_LAST;
  assign pat_done = pat_cnt == num_pat - 1'b1;
  always_comb begin
    state_n = (state == IDLE)  ? (START ? INIT : IDLE) :
              (state == INIT)  ? (init_done ? ((num_pat != '0) ? APPLY : FINISH) : INIT) :
              (state == APPLY) ? (pat_done ? FINISH : APPLY) : IDLE;
    lfsr_n = accept ? ((SEED == '0) ? LFSR_ONE : SEED) :
             (state == APPLY) ? lfsr_step(lfsr) : lfsr;
  end
  // DUT_PI looks ahead to the next state so the pattern on the pins lines up with the APPLY cycle that compacts it
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      state <= IDLE;
      lfsr <= LFSR_ONE;
      num_pat <= '0;
      golden <= '0;
      pat_cnt <= '0;
      init_cnt <= '0;
      DUT_PI <= PI_CLR;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      SIGNATURE <= '0;
      PASS <= 1'b0;
    end else begin
      state <= state_n;
      lfsr <= lfsr_n;
      DUT_PI <= (state_n == APPLY) ? {1'b0, lfsr_n[PI_W-2:0]} : PI_CLR;
      BUSY <= state_n != IDLE;
      DONE <= state == FINISH;
      pat_cnt <= accept ? '0 : (state == APPLY) ? pat_cnt + 1'b1 : pat_cnt;
      init_cnt <= accept ? '0 : (state == INIT) ? init_cnt + 1'b1 : init_cnt;
      if (accept) begin
        num_pat <= NUM_PAT;
        golden <= GOLDEN;
        PASS <= 1'b0;
      end
      if (state == FINISH) begin
        SIGNATURE <= misr_sig;
        PASS <= misr_sig == golden;
      end
    end
  s820_bist_misr u_misr (
    .clk(CK),
    .rst(RST),
    .clr(accept),
    .en (state == APPLY),
    .din(DUT_PO),
    .sig(misr_sig)
  );
endmodule

// File: tb/tb_s820_bist_ctrl.sv
// tb_s820_bist_ctrl: directed-step bench for s820_bist_ctrl with a stand-in combinational DUT response model
module tb_s820_bist_ctrl;
  logic CK = 0, RST = 0, START = 0;
  logic [17:0] SEED = 0;
  logic [15:0] NUM_PAT = 0;
  logic [18:0] GOLDEN = 0;
  logic [17:0] DUT_PI;
  logic [18:0] DUT_PO;
  logic BUSY, DONE, PASS;
  logic [18:0] SIGNATURE;
  logic [18:0] po_const = 0;
  bit use_model = 0;
  int n_chk = 0, n_err = 0;
  s820_bist_ctrl #(.INIT_CYC(2)) dut (
    .CK(CK), .RST(RST), .START(START), .SEED(SEED), .NUM_PAT(NUM_PAT), .GOLDEN(GOLDEN),
    .DUT_PI(DUT_PI), .DUT_PO(DUT_PO), .BUSY(BUSY), .DONE(DONE), .SIGNATURE(SIGNATURE), .PASS(PASS)
  );
  always #5 CK = ~CK;
  function automatic logic [18:0] po_f(input logic [17:0] pi);
    return {pi[0] ^ pi[5], pi} ^ ({1'b0, pi} << 3);
  endfunction
  always_comb DUT_PO = use_model ? po_f(DUT_PI) : po_const;
  function automatic logic [18:0] misr_ref(input logic [18:0] m, input logic [18:0] po);
    logic [18:0] n;
    n[0] = m[18] ^ po[0];
    for (int i = 1; i < 19; i++) n[i] = m[i-1] ^ po[i] ^ (((i == 1) || (i == 2) || (i == 6)) && m[18]);
    return n;
  endfunction
  function automatic logic [18:0] sw_sig(input logic [17:0] seed, input int np);
    logic [17:0] q;
    logic [18:0] m;
    q = (seed == 0) ? 18'h00001 : seed;
    m = 0;
    for (int k = 0; k < np; k++) begin
      m = misr_ref(m, po_f({1'b0, q[16:0]}));
      q = {q[16:0], q[17] ^ q[10]};
    end
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CK);
    #1;
  endtask
  task automatic start_session(input logic [17:0] s, input logic [15:0] np, input logic [18:0] g);
    SEED = s;
    NUM_PAT = np;
    GOLDEN = g;
    START = 1;
    tick();
    START = 0;
  endtask
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (DONE !== 1'b1 && c < 400) begin
      tick();
      c++;
    end
  endtask
  initial begin
    int c;
    bit bad;
    logic [18:0] exp_sig;
    #1 RST = 1;
    #2;
    chk("rst_pi", DUT_PI, 18'h20000);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sig", SIGNATURE, 0);
    chk("rst_pass", PASS, 0);
    tick();
    tick();
    RST = 0;
    // seed 1, three patterns, zero responses
    start_session(18'h1, 16'd3, 19'h0);
    chk("a_busy", BUSY, 1);
    chk("a_pi_init0", DUT_PI, 18'h20000);
    tick();
    chk("a_pi_init1", DUT_PI, 18'h20000);
    tick();
    chk("a_pi_p0", DUT_PI, 18'h00001);
    tick();
    chk("a_pi_p1", DUT_PI, 18'h00002);
    tick();
    chk("a_pi_p2", DUT_PI, 18'h00004);
    tick();
    chk("a_pi_fin", DUT_PI, 18'h20000);
    chk("a_done_early", DONE, 0);
    tick();
    chk("a_done", DONE, 1);
    chk("a_sig", SIGNATURE, 0);
    chk("a_pass", PASS, 1);
    chk("a_busy_end", BUSY, 0);
    tick();
    chk("a_done_pulse", DONE, 0);
    // all-ones response, one pattern
    po_const = 19'h7FFFF;
    start_session(18'h1, 16'd1, 19'h7FFFF);
    wait_done(0, c);
    chk("b_lat", c, 4);
    chk("b_sig", SIGNATURE, 19'h7FFFF);
    chk("b_pass", PASS, 1);
    tick();
    start_session(18'h1, 16'd1, 19'h0);
    wait_done(0, c);
    chk("b_sig2", SIGNATURE, 19'h7FFFF);
    chk("b_fail_pass", PASS, 0);
    tick();
    // zero-length session
    po_const = 0;
    start_session(18'h5, 16'd0, 19'h0);
    c = 0;
    bad = 0;
    while (DONE !== 1'b1 && c < 20) begin
      if (DUT_PI !== 18'h20000) bad = 1;
      tick();
      c++;
    end
    chk("c_lat", c, 3);
    chk("c_pi_clr", bad, 0);
    chk("c_sig", SIGNATURE, 0);
    chk("c_pass", PASS, 1);
    tick();
    // inputs disturbed mid-session
    use_model = 1;
    exp_sig = sw_sig(18'h1, 4);
    start_session(18'h1, 16'd4, exp_sig);
    tick();
    tick();
    tick();
    SEED = 18'h3ABCD;
    GOLDEN = 0;
    NUM_PAT = 16'd9;
    START = 1;
    tick();
    START = 0;
    wait_done(4, c);
    chk("d_lat", c, 7);
    chk("d_sig", SIGNATURE, exp_sig);
    chk("d_pass", PASS, 1);
    tick();
    // asynchronous reset mid-APPLY
    start_session(18'h1, 16'd10, 19'h0);
    tick();
    tick();
    tick();
    #2 RST = 1;
    #1;
    chk("f_pi", DUT_PI, 18'h20000);
    chk("f_busy", BUSY, 0);
    chk("f_done", DONE, 0);
    chk("f_sig", SIGNATURE, 0);
    chk("f_pass", PASS, 0);
    #1 RST = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0) bad = 1;
    end
    chk("f_no_done", bad, 0);
    // START held high: back-to-back sessions
    use_model = 0;
    SEED = 18'h1;
    NUM_PAT = 0;
    GOLDEN = 0;
    START = 1;
    tick();
    tick();
    tick();
    tick();
    chk("e_done", DONE, 1);
    chk("e_gap_busy", BUSY, 0);
    tick();
    chk("e_busy2", BUSY, 1);
    chk("e_done_low", DONE, 0);
    START = 0;
    wait_done(4, c);
    chk("e_lat2", c, 7);
    tick();
    // zero seed, 256 patterns against the software MISR
    use_model = 1;
    exp_sig = sw_sig(18'h0, 256);
    start_session(18'h0, 16'd256, exp_sig);
    tick();
    tick();
    chk("g_pi_first", DUT_PI, 18'h00001);
    wait_done(2, c);
    chk("g_lat", c, 259);
    chk("g_sig", SIGNATURE, exp_sig);
    chk("g_pass", PASS, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/s820_bist_ctrl.md
S820_BIST_CTRL -- requirements
Module: s820_bist_ctrl

Interface
REQ-001 Parameter: INIT_CYC, default 2, number of cycles the DUT clear input is held high before patterns (range 1..15).
REQ-002 Port: CK  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: START  input  1  session request, sampled in IDLE only.
REQ-005 Port: SEED  input  18  pattern LFSR seed, captured when START is accepted.
REQ-006 Port: NUM_PAT  input  16  pattern count, captured when START is accepted.
REQ-007 Port: GOLDEN  input  19  expected signature, captured when START is accepted.
REQ-008 Port: DUT_PI  output  18  DUT stimulus; bit i drives Gi for i=0..16, bit 17 drives G18 (synchronous state clear).
REQ-009 Port: DUT_PO  input  19  DUT responses, in bit order G43,G45,G47,G49,G53,G55,G288,G290,G292,G296,G298,G300,G302,G310,G312,G315,G322,G325,G327 (bit 0 first).
REQ-010 Port: BUSY  output  1  high in every state except IDLE.
REQ-011 Port: DONE  output  1  one-cycle pulse when a session ends.
REQ-012 Port: SIGNATURE  output  19  final MISR value, held until the next accepted START.
REQ-013 Port: PASS  output  1  SIGNATURE==GOLDEN, valid from DONE, held until the next accepted START.

Function
REQ-014 FSM states are IDLE, INIT, APPLY and FINISH; all outputs are registered.
REQ-015 In IDLE, START=1 captures SEED/NUM_PAT/GOLDEN, clears MISR to 0, clears both counters, clears PASS, and moves to INIT.
REQ-016 START in any state other than IDLE is ignored.
REQ-017 In IDLE and INIT, DUT_PI = 18'h20000 (G18=1 holds the DUT flops cleared, all other inputs 0).
REQ-018 INIT lasts exactly INIT_CYC cycles, then moves to APPLY when NUM_PAT!=0 or to FINISH when NUM_PAT==0.
REQ-019 In APPLY, DUT_PI = {1'b0, LFSR[16:0]}; G18 is forced 0.
REQ-020 The LFSR is 18-bit Fibonacci x^18+x^11+1: next = {q[16:0], q[17]^q[10]}; a zero seed is replaced by 18'h00001.
REQ-021 At each rising edge ending an APPLY cycle, MISR <= step(MISR, DUT_PO), the LFSR advances, and the pattern counter increments.
REQ-022 MISR step (x^19+x^6+x^2+x+1): m'[0]=m[18]^po[0]; for i=1..18, m'[i]=m[i-1]^po[i], additionally XORed with m[18] when i is 1, 2 or 6.
REQ-023 APPLY lasts exactly NUM_PAT cycles (one pattern per cycle), then moves to FINISH; a 16-bit counter, with no wrap within a session.
REQ-024 FINISH lasts one cycle: DONE=1, SIGNATURE<=MISR, PASS<=(MISR==GOLDEN), then return to IDLE.
REQ-025 DONE is high in the cycle that is INIT_CYC+NUM_PAT+1 edges after the START-accepting edge.
REQ-026 START held high through FINISH is accepted on the first IDLE cycle; back-to-back sessions therefore have a one-cycle IDLE gap.
REQ-027 Changes on SEED, NUM_PAT or GOLDEN during a session have no effect.

Reset
REQ-028 RST=1 forces, immediately and regardless of CK: state IDLE, DUT_PI=18'h20000, BUSY=0, DONE=0, SIGNATURE=0, PASS=0, MISR=0, LFSR=18'h00001, counters=0.
REQ-029 RST asserted mid-session abandons the session; no DONE is produced, and the next session needs a new START after RST falls.

Structure
REQ-030 Package s820_bist_pkg holds the state enum, widths (PI_W=18, PO_W=19, CNT_W=16), LFSR tap constant and MISR tap mask 19'h00047.
REQ-031 The MISR is a separate sub-module s820_bist_misr (ports: clock, reset, clear, enable, data in, signature out); the FSM, LFSR and counters stay in s820_bist_ctrl.

Verification
REQ-032 RST pulsed mid-APPLY -> outputs go to the REQ-028 values before the next CK edge; no DONE follows.
REQ-033 SEED=1, NUM_PAT=3, DUT_PO=0 -> APPLY drives DUT_PI 18'h00001, 18'h00002, 18'h00004; SIGNATURE=0; DONE exactly 6 cycles after START.
REQ-034 SEED=1, NUM_PAT=1, DUT_PO=19'h7FFFF, GOLDEN=19'h7FFFF -> SIGNATURE=19'h7FFFF, PASS=1; with GOLDEN=0 -> PASS=0.
REQ-035 NUM_PAT=0 -> INIT for 2 cycles, then FINISH; DONE 3 cycles after START; SIGNATURE=0; DUT_PI never leaves 18'h20000.
REQ-036 START pulsed during APPLY, and SEED/GOLDEN changed mid-session -> session length and signature are unchanged.
REQ-037 SEED=0 -> first APPLY pattern is 18'h00001; connect a reference s820 model and compare SIGNATURE against a software MISR over 256 patterns.
